load_store_unit: RTL and testbench
==================================

# load_store_unit

Pipeline-side initiator for the word-organised data memory. It accepts one load or store per request from the MEM stage. It converts byte addresses and byte/half/word sizes into full-word memory reads and writes, using read-modify-write for sub-word stores. It returns lane-extracted, sign- or zero-extended load data, and flags misaligned or out-of-range accesses without touching memory.

## Interface
Parameters:
- DEPTH_W, 6: word-index width; memory holds 2^DEPTH_W 32-bit words.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; request accepted when req_valid & req_ready at a clk edge.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  1 = byte, 2 = half, 3 = word; 0 is illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_error  out  1  valid with rsp_valid; misaligned, illegal size or out of range.
- mem_req  out  1  memory access in progress.
- mem_we  out  1  1 = word write, 0 = word read.
- mem_read  out  2  3 while a read is requested, else 0.
- mem_addr  out  32  word index {zeros, req_addr[DEPTH_W+1:2]}.
- mem_wdata  out  32  full write word.
- mem_rdata  in  32  read word; valid when mem_ack is high during a read.
- mem_ack  in  1  completes the current access; ignored when mem_req = 0.

## Operation
- States: IDLE, RD, WR, RESP. req_ready = 1 only in IDLE.
- On accept, register addr, size, signed, write and wdata. Then classify:
  - Error if size = 0, or size = 2 and addr[0] ≠ 0, or size = 3 and addr[1:0] ≠ 0, or addr[31:DEPTH_W+2] ≠ 0.
  - Error → RESP with rsp_error = 1. No memory access.
  - Load → RD.
  - Word store → WR with mem_wdata = wdata.
  - Byte/half store → RD.
- RD: mem_req = 1, mem_we = 0, mem_read = 3. Hold until mem_ack. On ack, capture mem_rdata.
  - Load: go to RESP.
  - Sub-word store: go to WR.
- Merge for sub-word stores, little-endian:
  - Byte: replace lane addr[1:0] (bits 8·k+7:8·k) with wdata[7:0].
  - Half: replace lane addr[1] with wdata[15:0].
  - All other bits come from the captured word.
- WR: mem_req = 1, mem_we = 1, mem_read = 0. Hold until mem_ack, then go to RESP.
- RESP: rsp_valid = 1 for one cycle, then IDLE.
- Load extraction:
  - Byte uses the lane selected by addr[1:0]; half uses the lane selected by addr[1].
  - Extend to 32 bits with bit 7 or bit 15 when signed = 1, otherwise with zeros.
- mem_addr, mem_wdata, mem_we and mem_read stay stable while mem_req = 1 and mem_ack = 0. All are 0 when mem_req = 0.

## Timing
- Reset, asynchronous on rst_n low:
  - State goes to IDLE.
  - mem_req, mem_we and rsp_valid go to 0 immediately.
  - mem_read, mem_addr, mem_wdata, rsp_rdata and rsp_error go to 0.
  - req_ready = 1 once rst_n is high.
- Reset mid-access abandons the request. No response is issued. A partial RMW never writes.
- Accept at edge N; mem_req is high from cycle N+1.
- With mem_ack high in the first request cycle (zero-wait memory), rsp_valid arrives in cycle:
  - N+2 for loads and word stores.
  - N+3 for byte/half stores.
  - N+1 for errors.
- Each wait cycle (mem_ack low) adds one cycle per access.
- After rsp_valid, req_ready returns the next cycle. Minimum spacing between accepts is latency + 1.
- req_valid while busy is ignored; the request must be held by the pipeline.
- mem_ack in the same cycle mem_req first rises counts as completion.

## Test plan
- Word load: mem[5] = 0x8899AABB, load word addr 0x14 → rsp_rdata 0x8899AABB, rsp_error 0, rsp_valid at accept + 2.
- Signed and unsigned byte load, addr 0x17, same word:
  - Signed → rsp_rdata 0xFFFFFF88.
  - Unsigned → 0x00000088.
- Half store RMW: mem[2] = 0x11223344, store half 0xBEEF at addr 0x0A:
  - One read, then one write with mem_wdata 0xBEEF3344.
  - rsp_valid at accept + 3.
- Misaligned word load at addr 0x06 → rsp_valid at accept + 1 with rsp_error 1 and rsp_rdata 0. mem_req never rises.
- Wait states: mem_ack held low 3 cycles during a byte store at addr 0x01:
  - mem_addr and mem_read stay stable throughout.
  - Write happens only after the read ack.
  - Byte lane 1 is replaced.
- Reset mid-RMW: rst_n low while in WR waiting for ack:
  - mem_req drops immediately, no rsp_valid.
  - Next request after reset completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-organised memory: sub-word stores use read-modify-write, loads return extended lanes.
// Latency: errors 1 cycle, loads/word stores 2, sub-word stores 3, plus memory wait cycles; requests accepted only in IDLE.
module load_store_unit #(
  parameter int DEPTH_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_read,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic        wr_q;
  logic [15:0] wd_q;
  logic        bad;
  logic [31:0] widx;

  assign req_ready = (state == IDLE);

  always_comb begin
    bad  = (req_size == 2'd0)
         | ((req_size == 2'd2) & req_addr[0])
         | ((req_size == 2'd3) & (|req_addr[1:0]))
         | (|(req_addr >> (DEPTH_W + 2)));
    widx = {{(32 - DEPTH_W){1'b0}}, req_addr[DEPTH_W+1:2]};
  end

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] ln,
                                        input logic [1:0] sz, input logic [15:0] d);
    logic [31:0] r;
    r = w;
    if (sz == 2'd1) r[{ln, 3'b000} +: 8] = d[7:0];
    else            r[{ln[1], 4'b0000} +: 16] = d;
    return r;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] ln,
                                          input logic [1:0] sz, input logic sg);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{ln, 3'b000} +: 8];
    h = w[{ln[1], 4'b0000} +: 16];
    case (sz)
      2'd1:    r = {{24{sg & b[7]}}, b};
      2'd2:    r = {{16{sg & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lane_q    <= 2'd0;
      size_q    <= 2'd0;
      sgn_q     <= 1'b0;
      wr_q      <= 1'b0;
      wd_q      <= 16'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_read  <= 2'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          lane_q <= req_addr[1:0];
          size_q <= req_size;
          sgn_q  <= req_signed;
          wr_q   <= req_write;
          wd_q   <= req_wdata[15:0];
          if (bad) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b1;
            rsp_rdata <= 32'd0;
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= widx;
            if (req_write && req_size == 2'd3) begin
              state     <= WR;
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata;
            end else begin
              state    <= RD;
              mem_read <= 2'd3;
            end
          end
        end
        RD: if (mem_ack) begin
          mem_read <= 2'd0;
          if (wr_q) begin
            // Sub-word store: keep the address, turn the read into the merged write.
            state     <= WR;
            mem_we    <= 1'b1;
            mem_wdata <= merge(mem_rdata, lane_q, size_q, wd_q);
          end else begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_addr  <= 32'd0;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b0;
            rsp_rdata <= extract(mem_rdata, lane_q, size_q, sgn_q);
          end
        end
        WR: if (mem_ack) begin
          state     <= RESP;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= 32'd0;
          mem_wdata <= 32'd0;
          rsp_valid <= 1'b1;
          rsp_error <= 1'b0;
          rsp_rdata <= 32'd0;
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_error <= 1'b0;
          rsp_rdata <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a wait-state memory model, a vector table and hand-written wait/reset sequences.
module tb_load_store_unit;
  localparam int DW = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, rsp_valid, rsp_error, mem_req, mem_we, mem_ack;
  logic [1:0]  mem_read;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Memory model with separate wait counts for reads and writes.
  logic [31:0] mem [0:63];
  int          rd_waits = 0, wr_waits = 0, wcnt = 0;
  int          n_rd = 0, n_wr = 0, stab_err = 0, idle_err = 0;
  logic [1:0]  hist = 2'b00;
  logic        bd_we = 1'b0;
  logic [5:0]  bd_idx = 6'd0;
  logic [31:0] bd_dat = 32'd0;
  logic        hold = 1'b0, h_we = 1'b0;
  logic [1:0]  h_read = 2'd0;
  logic [31:0] h_addr = 32'd0, h_wdata = 32'd0;

  assign mem_ack   = mem_req && (wcnt >= (mem_we ? wr_waits : rd_waits));
  assign mem_rdata = mem[mem_addr[DW-1:0]];

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_dat;
    else if (mem_req && mem_ack && mem_we) mem[mem_addr[DW-1:0]] <= mem_wdata;
    if (mem_req && mem_ack) begin
      hist <= {hist[0], mem_we};
      if (mem_we) n_wr <= n_wr + 1;
      else        n_rd <= n_rd + 1;
    end
    wcnt <= (!mem_req || mem_ack) ? 0 : wcnt + 1;
    if (hold && mem_req && (mem_addr !== h_addr || mem_we !== h_we ||
                            mem_read !== h_read || mem_wdata !== h_wdata))
      stab_err <= stab_err + 1;
    hold    <= mem_req && !mem_ack;
    h_addr  <= mem_addr;
    h_we    <= mem_we;
    h_read  <= mem_read;
    h_wdata <= mem_wdata;
  end

  always @(negedge clk)
    if (!mem_req && (mem_we || mem_read != 2'd0 || mem_addr != 32'd0 || mem_wdata != 32'd0))
      idle_err <= idle_err + 1;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
    int          nrd;
    int          nwr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] ex,
                              input logic er, input int lt, input int nr, input int nw);
    vec_t v;
    v.wr = wr; v.sz = sz; v.sg = sg; v.addr = a; v.wdata = wd; v.exp_rdata = ex;
    v.exp_err = er; v.lat = lt; v.nrd = nr; v.nwr = nw;
    return v;
  endfunction

  function automatic logic [31:0] init_val(input int i);
    case (i)
      0:       return 32'hA0B0C0D0;
      1:       return 32'h0BADBEEF;
      2:       return 32'h11223344;
      3:       return 32'h0000807F;
      5:       return 32'h8899AABB;
      63:      return 32'hCAFEF00D;
      default: return 32'h0;
    endcase
  endfunction

  // Issue one request and measure cycles from accept edge to the rsp_valid cycle.
  task automatic run_op(input int idx, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic err);
    logic found;
    @(negedge clk);
    chk("ready", idx, 32'(req_ready), 32'd1);
    req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; rd = 32'd0; err = 1'b0; found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        rd = rsp_rdata; err = rsp_error; found = 1'b1;
      end
    end
    @(negedge clk);
    chk("pulse", idx, {30'd0, rsp_valid, req_ready}, 32'd1);
  endtask

  int          lat, r0, w0, seen;
  logic [31:0] rd;
  logic        err;

  initial begin
    tv.push_back(mk(0, 3, 0, 32'h14, 0, 32'h8899AABB, 0, 2, 1, 0));
    tv.push_back(mk(0, 1, 1, 32'h17, 0, 32'hFFFFFF88, 0, 2, 1, 0));
    tv.push_back(mk(0, 1, 0, 32'h17, 0, 32'h00000088, 0, 2, 1, 0));
    tv.push_back(mk(0, 1, 1, 32'h14, 0, 32'hFFFFFFBB, 0, 2, 1, 0));
    tv.push_back(mk(0, 1, 0, 32'h15, 0, 32'h000000AA, 0, 2, 1, 0));
    tv.push_back(mk(0, 2, 1, 32'h16, 0, 32'hFFFF8899, 0, 2, 1, 0));
    tv.push_back(mk(0, 2, 0, 32'h14, 0, 32'h0000AABB, 0, 2, 1, 0));
    tv.push_back(mk(0, 2, 1, 32'h0C, 0, 32'hFFFF807F, 0, 2, 1, 0));
    tv.push_back(mk(0, 1, 1, 32'h0C, 0, 32'h0000007F, 0, 2, 1, 0));
    tv.push_back(mk(0, 1, 1, 32'h0D, 0, 32'hFFFFFF80, 0, 2, 1, 0));
    tv.push_back(mk(1, 2, 0, 32'h0A, 32'h0000BEEF, 0, 0, 3, 1, 1));
    tv.push_back(mk(0, 3, 0, 32'h08, 0, 32'hBEEF3344, 0, 2, 1, 0));
    tv.push_back(mk(1, 3, 0, 32'h10, 32'h12345678, 0, 0, 2, 0, 1));
    tv.push_back(mk(1, 1, 0, 32'h13, 32'h000000AB, 0, 0, 3, 1, 1));
    tv.push_back(mk(0, 3, 0, 32'h10, 0, 32'hAB345678, 0, 2, 1, 0));
    tv.push_back(mk(0, 3, 0, 32'h06, 0, 0, 1, 1, 0, 0));
    tv.push_back(mk(0, 2, 0, 32'h05, 0, 0, 1, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 32'h00, 0, 0, 1, 1, 0, 0));
    tv.push_back(mk(0, 3, 0, 32'h100, 0, 0, 1, 1, 0, 0));
    tv.push_back(mk(0, 1, 0, 32'h80000000, 0, 0, 1, 1, 0, 0));
    tv.push_back(mk(1, 3, 0, 32'h02, 32'hFFFFFFFF, 0, 1, 1, 0, 0));
    tv.push_back(mk(1, 2, 0, 32'h03, 32'hFFFFFFFF, 0, 1, 1, 0, 0));
    tv.push_back(mk(0, 3, 0, 32'hFC, 0, 32'hCAFEF00D, 0, 2, 1, 0));
    tv.push_back(mk(0, 1, 0, 32'hFF, 0, 32'h000000CA, 0, 2, 1, 0));
    tv.push_back(mk(1, 1, 0, 32'hFD, 32'hFFFFFF5A, 0, 0, 3, 1, 1));
    tv.push_back(mk(0, 3, 0, 32'hFC, 0, 32'hCAFE5A0D, 0, 2, 1, 0));
    tv.push_back(mk(1, 2, 0, 32'h06, 32'hFFFF1234, 0, 0, 3, 1, 1));
    tv.push_back(mk(0, 3, 0, 32'h04, 0, 32'h1234BEEF, 0, 2, 1, 0));

    // Preload memory through the backdoor while held in reset.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      bd_we = 1'b1; bd_idx = 6'(i); bd_dat = init_val(i);
    end
    @(negedge clk);
    bd_we = 1'b0;
    chk("rst_mem_req", 0, 32'(mem_req), 32'd0);
    chk("rst_rsp_valid", 0, 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 0, rsp_rdata, 32'd0);
    chk("rst_rsp_error", 0, 32'(rsp_error), 32'd0);
    chk("rst_mem_read", 0, 32'(mem_read), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 0, 32'(req_ready), 32'd1);

    foreach (tv[i]) begin
      r0 = n_rd; w0 = n_wr;
      run_op(i, tv[i].wr, tv[i].sz, tv[i].sg, tv[i].addr, tv[i].wdata, lat, rd, err);
      chk("rdata", i, rd, tv[i].exp_rdata);
      chk("error", i, 32'(err), 32'(tv[i].exp_err));
      chk("latency", i, 32'(lat), 32'(tv[i].lat));
      chk("reads", i, 32'(n_rd - r0), 32'(tv[i].nrd));
      chk("writes", i, 32'(n_wr - w0), 32'(tv[i].nwr));
    end

    // Byte store at 0x01 with three wait cycles on each access.
    rd_waits = 3; wr_waits = 3;
    r0 = n_rd; w0 = n_wr;
    run_op(100, 1'b1, 2'd1, 1'b0, 32'h01, 32'h00000077, lat, rd, err);
    chk("wait_latency", 100, 32'(lat), 32'd9);
    chk("wait_error", 100, 32'(err), 32'd0);
    chk("wait_reads", 100, 32'(n_rd - r0), 32'd1);
    chk("wait_writes", 100, 32'(n_wr - w0), 32'd1);
    chk("wait_order", 100, 32'(hist), 32'd1);
    chk("wait_stable", 100, 32'(stab_err), 32'd0);
    rd_waits = 0; wr_waits = 0;
    run_op(101, 1'b0, 2'd3, 1'b0, 32'h00, 32'h0, lat, rd, err);
    chk("wait_merge", 101, rd, 32'hA0B077D0);

    // Reset while the RMW write is stalled.
    wr_waits = 20;
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0; req_addr = 32'h04; req_wdata = 32'h99;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clk);
      if (mem_req && mem_we) seen = 1;
    end
    chk("rst_reach_wr", 200, 32'(seen), 32'd1);
    @(negedge clk);
    @(negedge clk);
    w0 = n_wr;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_req", 200, 32'(mem_req), 32'd0);
    chk("rst_mid_mem_we", 200, 32'(mem_we), 32'd0);
    chk("rst_mid_rsp", 200, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wr_waits = 0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("rst_no_rsp", 200, 32'(seen), 32'd0);
    chk("rst_no_write", 200, 32'(n_wr - w0), 32'd0);
    run_op(201, 1'b0, 2'd3, 1'b0, 32'h04, 32'h0, lat, rd, err);
    chk("post_rst_rdata", 201, rd, 32'h1234BEEF);
    chk("post_rst_latency", 201, 32'(lat), 32'd2);

    chk("idle_outputs_zero", 300, 32'(idle_err), 32'd0);
    chk("hold_stable", 300, 32'(stab_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
